// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a radix-2 Booth add/sub-and-shift for MUL,
// or one restoring subtract-and-shift on magnitudes for DIV.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 i_op,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [2*WIDTH-1:0]   i_mcand,
    input  logic [1:0]           i_booth,
    input  logic [WIDTH:0]       i_rem,
    input  logic [WIDTH-1:0]     i_quo,
    input  logic [WIDTH:0]       i_dvsr,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [2*WIDTH-1:0]   o_mcand,
    output logic [WIDTH:0]       o_rem,
    output logic [WIDTH-1:0]     o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // The partial remainder is always below the divisor, so the shifted value fits W+1 bits.
    assign w_shift = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    assign w_ge    = i_rem[WIDTH] | (w_shift >= i_dvsr);
    assign w_diff  = w_shift - i_dvsr;

    always_comb begin
        o_acc   = i_acc;
        o_mcand = i_mcand;
        o_rem   = i_rem;
        o_quo   = i_quo;
        if (i_op == OP_MUL) begin
            case (i_booth)
                2'b01:   o_acc = i_acc + i_mcand;
                2'b10:   o_acc = i_acc - i_mcand;
                default: o_acc = i_acc;
            endcase
            o_mcand = i_mcand << 1;
        end else begin
            if (w_ge) begin
                o_rem = w_diff;
                o_quo = {i_quo[WIDTH-2:0], 1'b1};
            end else begin
                o_rem = w_shift;
                o_quo = {i_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide: owns the FSM, iteration counter, operand
// and result registers; one muldiv_step iteration per clock in RUN.
//   state   | meaning
//   IDLE    | waiting for start, operands latched on acceptance
//   RUN     | one Booth / restoring iteration per cycle, counter counts down
//   FIX     | sign correction, HI/LO registered at the end of this cycle
//   DONE    | one-cycle done pulse, then back to IDLE
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_dbz_req;

    logic [CW-1:0]        r_cnt;
    logic                 r_op;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_a;
    logic                 r_sign_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic                 r_prev;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH:0]       r_dvsr;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_div_by_zero;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_acc_nx;
    logic [2*WIDTH-1:0]   w_mcand_nx;
    logic [WIDTH:0]       w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;

    // W-bit unsigned magnitude is exact even for the most negative operand.
    assign w_abs_a   = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_abs_b   = i_b[WIDTH-1] ? -i_b : i_b;
    assign w_dbz_req = (i_op == OP_DIV) && (i_b == '0);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op    (r_op),
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_booth ({r_mplr[0], r_prev}),
        .i_rem   (r_rem),
        .i_quo   (r_quo),
        .i_dvsr  (r_dvsr),
        .o_acc   (w_acc_nx),
        .o_mcand (w_mcand_nx),
        .o_rem   (w_rem_nx),
        .o_quo   (w_quo_nx)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = w_dbz_req ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort)            w_next = ST_IDLE;
                else if (r_cnt == '0)   w_next = ST_FIX;
            end
            ST_FIX:  w_next = i_abort ? ST_IDLE : ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_dbz    <= 1'b0;
            r_a      <= '0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_prev   <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else if (w_accept) begin
            r_cnt    <= w_dbz_req ? '0 : CW'(WIDTH - 1);
            r_op     <= i_op;
            r_dbz    <= w_dbz_req;
            r_a      <= i_a;
            r_sign_b <= i_b[WIDTH-1];
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{i_a[WIDTH-1]}}, i_a};
            r_mplr   <= i_b;
            r_prev   <= 1'b0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvsr   <= {1'b0, w_abs_b};
        end else if (r_state == ST_RUN) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            r_acc   <= w_acc_nx;
            r_mcand <= w_mcand_nx;
            r_mplr  <= r_mplr >> 1;
            r_prev  <= r_mplr[0];
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_by_zero <= 1'b0;
        end else if (r_state == ST_FIX && !i_abort) begin
            if (r_dbz) begin
                r_hi          <= r_a;
                r_lo          <= '1;
                r_div_by_zero <= 1'b1;
            end else if (r_op == OP_DIV) begin
                r_hi          <= r_a[WIDTH-1] ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                r_lo          <= (r_a[WIDTH-1] ^ r_sign_b) ? -r_quo : r_quo;
                r_div_by_zero <= 1'b0;
            end else begin
                r_hi          <= r_acc[2*WIDTH-1:WIDTH];
                r_lo          <= r_acc[WIDTH-1:0];
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_div_by_zero = r_div_by_zero;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer plus abort/reset/ignored-start sequences
// and a signed sweep against native 64-bit arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_op          (op),
        .i_abort       (abort),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents an op so that it is sampled at "edge 0"; returns inside cycle 1.
    task automatic issue(input logic o, input logic [31:0] va, input logic [31:0] vb);
        @(posedge clk);
        #1;
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        #1;
        cyc = 1;
        start = 1'b0; op = ~o; a = ~va; b = ~vb;
    endtask

    // Scans forward from the current cycle for done; lat = -1 if it never arrives.
    task automatic wait_done(output int lat, output logic [31:0] rh, output logic [31:0] rl,
                             output logic rd);
        lat = -1; rh = '0; rl = '0; rd = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc; rh = hi; rl = lo; rd = dbz;
                break;
            end
            next_cycle();
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        logic [31:0] rh, rl;
        logic rd;
        issue(v.op, v.a, v.b);
        wait_done(lat, rh, rl, rd);
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " hi"}, 64'(rh), 64'(v.hi));
        check({tag, " lo"}, 64'(rl), 64'(v.lo));
        check({tag, " div_by_zero"}, 64'(rd), 64'(v.dbz));
        next_cycle();
        @(negedge clk);
        check({tag, " busy after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] rh, rl;
        logic rd;
        longint sa, sb, prod, q, r;
        vec_t v;

        vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[4]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
        vecs[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[8]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34};
        vecs[10] = '{1'b0, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 34};
        vecs[11] = '{1'b1, 32'd5,        32'd7,        32'h00000005, 32'h00000000, 1'b0, 34};
        vecs[12] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
        vecs[13] = '{1'b1, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1, 2};
        vecs[14] = '{1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 34};

        // reset state
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset dbz", 64'(dbz), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // start re-pulsed while busy is ignored
        issue(1'b0, 32'd3, 32'd4);
        while (cyc < 10) next_cycle();
        start = 1'b1; op = 1'b0; a = 32'd100; b = 32'd100;
        next_cycle();
        start = 1'b0;
        wait_done(lat, rh, rl, rd);
        check("ignored start latency", 64'(lat), 64'd34);
        check("ignored start lo", 64'(rl), 64'd12);
        check("ignored start hi", 64'(rh), 64'd0);

        // abort mid-RUN
        issue(1'b0, 32'd9, 32'd9);
        while (cyc < 20) next_cycle();
        abort = 1'b1;
        @(negedge clk);
        check("abort busy cycle 20", 64'(busy), 64'd1);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort idle cycle 21", 64'(busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);
        check("abort hi kept", 64'(hi), 64'd0);
        check("abort lo kept", 64'(lo), 64'd12);

        // asynchronous reset mid-DIV
        issue(1'b1, 32'd1000, 32'd3);
        while (cyc < 15) next_cycle();
        rst_n = 1'b0;
        #1;
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset done", 64'(done), 64'd0);
        check("mid-op reset hi", 64'(hi), 64'd0);
        check("mid-op reset lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        v = '{1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34};
        run_vec("post-reset mul", v);

        // signed sweep against native arithmetic
        for (int i = 0; i < 16; i++) begin
            v.op = i[0];
            v.a  = $urandom();
            v.b  = (i % 4 == 1) ? 32'($urandom_range(1, 40)) : $urandom();
            if (v.op == 1'b1 && v.b == '0) v.b = 32'd1;
            sa = longint'($signed(v.a));
            sb = longint'($signed(v.b));
            if (v.op == 1'b0) begin
                prod = sa * sb;
                v.hi = prod[63:32];
                v.lo = prod[31:0];
            end else begin
                q = sa / sb;
                r = sa % sb;
                v.hi = r[31:0];
                v.lo = q[31:0];
            end
            v.dbz = 1'b0;
            v.lat = 34;
            run_vec($sformatf("sweep%0d", i), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
